// File: rtl/led_pkg.sv
// Shared types for the LED pattern controller: channel modes, command FSM states
// and the per-channel drive helper used by the output mux.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_ON     = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_BREATH = 2'd3
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_e;

   localparam int MODE_W = 3;

   typedef struct packed {
      logic  inv;
      mode_e mode;
   } chan_cfg_t;

   // Counter width for a 0..range-1 count; never narrower than one bit.
   function automatic int cnt_w(input int range);
      return (range > 1) ? $clog2(range) : 1;
   endfunction

   // inv only matters in BREATH, where it selects the anti-phase waveform.
   function automatic logic chan_value(input chan_cfg_t cfg, input logic blink, input logic breath);
      logic v;
      case (cfg.mode)
         MODE_OFF:    v = 1'b0;
         MODE_ON:     v = 1'b1;
         MODE_BLINK:  v = blink;
         default:     v = breath ^ cfg.inv;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/led_timebase.sv
// Shared PWM/ramp/blink timebase; every count advances on the pulse of the stage below it.
// Free-running, no backpressure; frame_end_o is combinational from the registered counters.
module led_timebase
   import led_pkg::*;
#(
   parameter int TICK_DIV     = 100,
   parameter int STEPS        = 1000,
   parameter int BLINK_FRAMES = 250,
   localparam int TICK_W      = cnt_w(TICK_DIV),
   localparam int PWM_W       = cnt_w(STEPS),
   localparam int BLK_W       = cnt_w(BLINK_FRAMES)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   output logic             tick_o,
   output logic             frame_end_o,
   output logic [PWM_W-1:0] cnt_pwm_o,
   output logic [PWM_W-1:0] cnt_ramp_o,
   output logic             dir_o,
   output logic             blink_state_o
);

   logic [TICK_W-1:0] cnt_tick_q, cnt_tick_d;
   logic [PWM_W-1:0]  cnt_pwm_q, cnt_pwm_d;
   logic [PWM_W-1:0]  cnt_ramp_q, cnt_ramp_d;
   logic [BLK_W-1:0]  cnt_blink_q, cnt_blink_d;
   logic              dir_q, dir_d;
   logic              blink_q, blink_d;
   logic              tick, frame_end;

   assign tick      = (cnt_tick_q == TICK_W'(TICK_DIV - 1));
   assign frame_end = tick && (cnt_pwm_q == PWM_W'(STEPS - 1));

   always_comb begin
      cnt_tick_d  = tick ? '0 : cnt_tick_q + TICK_W'(1);
      cnt_pwm_d   = cnt_pwm_q;
      cnt_ramp_d  = cnt_ramp_q;
      cnt_blink_d = cnt_blink_q;
      dir_d       = dir_q;
      blink_d     = blink_q;
      if (tick) begin
         cnt_pwm_d = (cnt_pwm_q == PWM_W'(STEPS - 1)) ? '0 : cnt_pwm_q + PWM_W'(1);
      end
      if (frame_end) begin
         if (cnt_ramp_q == PWM_W'(STEPS - 1)) begin
            cnt_ramp_d = '0;
            dir_d      = ~dir_q;
         end else begin
            cnt_ramp_d = cnt_ramp_q + PWM_W'(1);
         end
         if (cnt_blink_q == BLK_W'(BLINK_FRAMES - 1)) begin
            cnt_blink_d = '0;
            blink_d     = ~blink_q;
         end else begin
            cnt_blink_d = cnt_blink_q + BLK_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_tick_q  <= '0;
         cnt_pwm_q   <= '0;
         cnt_ramp_q  <= '0;
         cnt_blink_q <= '0;
         dir_q       <= 1'b0;
         blink_q     <= 1'b0;
      end else begin
         cnt_tick_q  <= cnt_tick_d;
         cnt_pwm_q   <= cnt_pwm_d;
         cnt_ramp_q  <= cnt_ramp_d;
         cnt_blink_q <= cnt_blink_d;
         dir_q       <= dir_d;
         blink_q     <= blink_d;
      end
   end

   // dir_o = 0 while the breath ramp is rising.
   assign tick_o        = tick;
   assign frame_end_o   = frame_end;
   assign cnt_pwm_o     = cnt_pwm_q;
   assign cnt_ramp_o    = cnt_ramp_q;
   assign dir_o         = dir_q;
   assign blink_state_o = blink_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Four-channel LED pattern controller; led is registered one cycle after the counters.
// Commands use valid/ready; ready drops while a command waits for the next frame boundary.
module led_pattern_ctrl
   import led_pkg::*;
#(
   parameter int TICK_DIV     = 100,
   parameter int STEPS        = 1000,
   parameter int BLINK_FRAMES = 250
) (
   input  logic          sclk,
   input  logic          s_rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [3:0]    cmd_mask,
   input  logic [1:0]    cmd_mode,
   input  logic          cmd_inv,
   output logic [11:0]   mode_q,
   output logic          frame_end,
   output logic [3:0]    led
);

   localparam int PWM_W = cnt_w(STEPS);

   logic             tick_unused;
   logic [PWM_W-1:0] cnt_pwm, cnt_ramp;
   logic             dir, blink_state, breath;

   state_e           state_q, state_d;
   logic [3:0]       pend_mask_q, pend_mask_d;
   chan_cfg_t        pend_cfg_q, pend_cfg_d;
   chan_cfg_t        cfg_q [4];
   chan_cfg_t        cfg_d [4];
   logic [3:0]       led_q, led_d;
   logic             apply;

   led_timebase #(
      .TICK_DIV     (TICK_DIV),
      .STEPS        (STEPS),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_timebase (
      .clk_i         (sclk),
      .rst_ni        (s_rst_n),
      .tick_o        (tick_unused),
      .frame_end_o   (frame_end),
      .cnt_pwm_o     (cnt_pwm),
      .cnt_ramp_o    (cnt_ramp),
      .dir_o         (dir),
      .blink_state_o (blink_state)
   );

   // A frame_end in the acceptance cycle is seen in IDLE, so it never applies the command.
   always_comb begin
      state_d     = state_q;
      cmd_ready   = 1'b0;
      apply       = 1'b0;
      pend_mask_d = pend_mask_q;
      pend_cfg_d  = pend_cfg_q;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               pend_mask_d = cmd_mask;
               pend_cfg_d  = '{inv: cmd_inv, mode: mode_e'(cmd_mode)};
               state_d     = PEND;
            end
         end
         default: begin
            if (frame_end) begin
               apply   = 1'b1;
               state_d = IDLE;
            end
         end
      endcase
   end

   assign breath = dir ? (cnt_pwm >= cnt_ramp) : (cnt_pwm < cnt_ramp);

   always_comb begin
      mode_q = '0;
      for (int i = 0; i < 4; i++) begin
         cfg_d[i]                       = (apply && pend_mask_q[i]) ? pend_cfg_q : cfg_q[i];
         led_d[i]                       = chan_value(cfg_q[i], blink_state, breath);
         mode_q[MODE_W*i +: MODE_W]     = cfg_q[i];
      end
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q     <= IDLE;
         pend_mask_q <= '0;
         pend_cfg_q  <= '0;
         led_q       <= '0;
         for (int i = 0; i < 4; i++) begin
            cfg_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         pend_mask_q <= pend_mask_d;
         pend_cfg_q  <= pend_cfg_d;
         led_q       <= led_d;
         for (int i = 0; i < 4; i++) begin
            cfg_q[i] <= cfg_d[i];
         end
      end
   end

   assign led = led_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios plus random commands, checked every
// cycle against a model that derives all timing from the cycle count since reset.
module tb_led_pattern_ctrl;

   localparam int TD    = 4;
   localparam int ST    = 8;
   localparam int BF    = 2;
   localparam int FRAME = TD * ST;

   logic        sclk      = 1'b0;
   logic        s_rst_n   = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_mask  = 4'd0;
   logic [1:0]  cmd_mode  = 2'd0;
   logic        cmd_inv   = 1'b0;
   logic [11:0] mode_q;
   logic        frame_end;
   logic [3:0]  led;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 sclk = ~sclk;

   led_pattern_ctrl #(.TICK_DIV(TD), .STEPS(ST), .BLINK_FRAMES(BF)) dut (
      .sclk      (sclk),
      .s_rst_n   (s_rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mask  (cmd_mask),
      .cmd_mode  (cmd_mode),
      .cmd_inv   (cmd_inv),
      .mode_q    (mode_q),
      .frame_end (frame_end),
      .led       (led)
   );

   typedef struct {
      int         at;
      logic [3:0] mask;
      logic [1:0] mode;
      logic       inv;
   } req_t;

   // Reference state: cycle count since reset, per-channel {inv,mode}, one pending command.
   int         n;
   logic [2:0] cfg_m [4];
   logic [3:0] led_m;
   bit         pend_m;
   logic [3:0] pmask_m;
   logic [2:0] pcfg_m;
   req_t       rq [$];
   int         acc_log [$];
   int         win_lo, win_hi, win_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, n);
      end
   endtask

   function automatic logic ref_led(input logic [2:0] cfg, input int cyc);
      int frame, pwm, ramp;
      bit falling, blink, br;
      frame   = cyc / FRAME;
      pwm     = (cyc / TD) % ST;
      ramp    = frame % ST;
      falling = ((frame / ST) % 2) == 1;
      blink   = ((frame / BF) % 2) == 1;
      br      = falling ? (pwm >= ramp) : (pwm < ramp);
      case (cfg[1:0])
         2'd0:    return 1'b0;
         2'd1:    return 1'b1;
         2'd2:    return blink;
         default: return br ^ cfg[2];
      endcase
   endfunction

   task automatic model_clear();
      n       = 0;
      led_m   = '0;
      pend_m  = 0;
      pmask_m = '0;
      pcfg_m  = '0;
      for (int i = 0; i < 4; i++) cfg_m[i] = '0;
      rq.delete();
      acc_log.delete();
      win_lo  = -1;
      win_hi  = -2;
      win_cnt = 0;
   endtask

   // Called at a negedge; asserts reset off-edge, optionally checks the async clear.
   task automatic do_reset(input bit chk);
      #2 s_rst_n = 1'b0;
      cmd_valid = 1'b0;
      #1;
      if (chk) begin
         check("rst_led", led, 0);
         check("rst_mode_q", mode_q, 0);
         check("rst_cmd_ready", cmd_ready, 1);
         check("rst_frame_end", frame_end, 0);
      end
      @(negedge sclk);
      @(negedge sclk);
      s_rst_n = 1'b1;
      model_clear();
   endtask

   task automatic push(input int at, input logic [3:0] mask, input logic [1:0] mode, input logic inv);
      req_t r;
      r.at = at; r.mask = mask; r.mode = mode; r.inv = inv;
      rq.push_back(r);
   endtask

   task automatic run(input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         logic        fe_m;
         logic [11:0] mq_m;
         logic [3:0]  nled;
         bit          acc;
         fe_m = ((n % FRAME) == FRAME - 1);
         for (int i = 0; i < 4; i++) mq_m[3*i +: 3] = cfg_m[i];
         check("led", led, led_m);
         check("cmd_ready", cmd_ready, !pend_m);
         check("frame_end", frame_end, fe_m);
         check("mode_q", mode_q, mq_m);
         if (n >= win_lo && n <= win_hi) begin
            if (led[0]) win_cnt++;
            check("led1_antiphase", led[1], !led[0]);
         end
         cmd_valid = 1'b0;
         cmd_mask  = 4'($urandom);
         cmd_mode  = 2'($urandom);
         cmd_inv   = 1'($urandom);
         if (rq.size() > 0 && n >= rq[0].at) begin
            cmd_valid = 1'b1;
            cmd_mask  = rq[0].mask;
            cmd_mode  = rq[0].mode;
            cmd_inv   = rq[0].inv;
         end
         acc = cmd_valid && !pend_m;
         for (int i = 0; i < 4; i++) nled[i] = ref_led(cfg_m[i], n);
         if (pend_m && fe_m) begin
            for (int i = 0; i < 4; i++) if (pmask_m[i]) cfg_m[i] = pcfg_m;
            pend_m = 0;
         end
         if (acc) begin
            pend_m  = 1;
            pmask_m = cmd_mask;
            pcfg_m  = {cmd_inv, cmd_mode};
            acc_log.push_back(n);
            void'(rq.pop_front());
         end
         led_m = nled;
         n++;
         @(negedge sclk);
      end
   endtask

   function automatic int acc_at(input int idx);
      return (acc_log.size() > idx) ? acc_log[idx] : -1;
   endfunction

   initial begin
      int t;
      model_clear();
      @(negedge sclk);
      do_reset(0);

      // Idle after reset: dark LEDs, frame_end every 32 cycles.
      run(70);

      // Single ON command on channel 0.
      do_reset(0);
      push(5, 4'b0001, 2'd1, 1'b0);
      run(70);
      check("s2_accept_cycle", acc_at(0), 5);

      // Accepted on a frame_end cycle: applies one frame later.
      do_reset(0);
      push(31, 4'b1111, 2'd2, 1'b0);
      run(300);
      check("s3_accept_cycle", acc_at(0), 31);

      // BREATH on ch0 (normal) and ch1 (anti-phase).
      do_reset(0);
      push(0, 4'b0001, 2'd3, 1'b0);
      push(0, 4'b0010, 2'd3, 1'b1);
      win_lo = 3 * FRAME + 1; win_hi = 4 * FRAME; win_cnt = 0;
      run(4 * FRAME + 2);
      check("s4_rise_ramp3_high", win_cnt, 12);
      win_lo = 8 * FRAME + 1; win_hi = 9 * FRAME; win_cnt = 0;
      run(5 * FRAME);
      check("s4_fall_ramp0_high", win_cnt, 32);

      // Back-to-back, including a mask=0 command.
      do_reset(0);
      push(2, 4'b0011, 2'd1, 1'b0);
      push(2, 4'b0000, 2'd3, 1'b1);
      push(2, 4'b0100, 2'd2, 1'b0);
      run(130);
      check("s5_accept0", acc_at(0), 2);
      check("s5_accept1", acc_at(1), 32);
      check("s5_accept2", acc_at(2), 64);

      // Reset while a command is pending.
      do_reset(0);
      push(3, 4'b1111, 2'd1, 1'b0);
      run(10);
      check("s6_pending", cmd_ready, 0);
      do_reset(1);
      run(100);

      // Random commands with random gaps.
      do_reset(0);
      t = 0;
      for (int c = 0; c < 40; c++) begin
         t += $urandom_range(0, 60);
         push(t, 4'($urandom), 2'($urandom), 1'($urandom));
      end
      run(3000);
      check("rand_all_accepted", rq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
